// File: rtl/multi_input_conditioner.sv
// Multi-channel synchroniser + debouncer with single-cycle edge pulses.
// Optional sticky edge flags are built only when INCOND_STICKY_EN is defined.
module multi_input_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int WAITTIME     = 3,
  parameter int COUNTERWIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic                anyedge,
  input  logic [CHANNELS-1:0] flagclear,
  output logic [CHANNELS-1:0] posflag,
  output logic [CHANNELS-1:0] negflag
);

  localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);
  localparam logic [COUNTERWIDTH-1:0] ONE_C  = COUNTERWIDTH'(1);

  logic [SYNC_STAGES-1:0]  sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0]  sync_d [CHANNELS];
  logic [COUNTERWIDTH-1:0] cnt_q  [CHANNELS];
  logic [COUNTERWIDTH-1:0] cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]     cond_q, cond_d;
  logic [CHANNELS-1:0]     pos_q, pos_d;
  logic [CHANNELS-1:0]     neg_q, neg_d;

  // A mismatch must survive WAITTIME+1 consecutive cycles; any agreement restarts the count.
  always_comb begin
    cond_d = cond_q;
    pos_d  = '0;
    neg_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], noisysignal[i]};
      cnt_d[i]  = '0;
      if (sync_q[i][SYNC_STAGES-1] != cond_q[i]) begin
        if (cnt_q[i] == WAIT_C) begin
          cond_d[i] = sync_q[i][SYNC_STAGES-1];
          pos_d[i]  = sync_q[i][SYNC_STAGES-1];
          neg_d[i]  = ~sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      cond_q <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign anyedge      = |{pos_q, neg_q};

`ifdef INCOND_STICKY_EN
  logic [CHANNELS-1:0] posflag_q, posflag_d;
  logic [CHANNELS-1:0] negflag_q, negflag_d;

  // Set takes priority over a clear arriving in the same cycle.
  always_comb begin
    posflag_d = pos_d | (posflag_q & ~flagclear);
    negflag_d = neg_d | (negflag_q & ~flagclear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      posflag_q <= '0;
      negflag_q <= '0;
    end else begin
      posflag_q <= posflag_d;
      negflag_q <= negflag_d;
    end
  end

  assign posflag = posflag_q;
  assign negflag = negflag_q;
`else
  logic unused_flagclear;
  assign unused_flagclear = ^flagclear;
  assign posflag = '0;
  assign negflag = '0;
`endif

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Bench for multi_input_conditioner: vector table on the default instance,
// hand sequences on an 8-channel/3-stage/WAITTIME=7 instance.
module tb_multi_input_conditioner;

`ifdef INCOND_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] noisy = '0, clr = '0;
  logic [3:0] cond, pos, neg, pf, nf;
  logic       any;

  logic       reset2 = 1'b1;
  logic [7:0] noisy2 = '0, clr2 = '1;
  logic [7:0] cond2, pos2, neg2, pf2, nf2;
  logic       any2;

  multi_input_conditioner dut (
    .clk(clk), .reset(reset), .noisysignal(noisy), .conditioned(cond),
    .positiveedge(pos), .negativeedge(neg), .anyedge(any),
    .flagclear(clr), .posflag(pf), .negflag(nf)
  );

  multi_input_conditioner #(
    .CHANNELS(8), .SYNC_STAGES(3), .WAITTIME(7), .COUNTERWIDTH(3)
  ) dut_wide (
    .clk(clk), .reset(reset2), .noisysignal(noisy2), .conditioned(cond2),
    .positiveedge(pos2), .negativeedge(neg2), .anyedge(any2),
    .flagclear(clr2), .posflag(pf2), .negflag(nf2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] n, clr, cond, pos, neg, pf, nf;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  // Each record: inputs applied before an edge, outputs expected just after it.
  function automatic void add(input int rep, input logic rst, input logic [3:0] n,
                              input logic [3:0] c, input logic [3:0] cd,
                              input logic [3:0] p, input logic [3:0] ng,
                              input logic [3:0] f_p, input logic [3:0] f_n);
    vec_t v;
    v.rst = rst; v.n = n; v.clr = c; v.cond = cd; v.pos = p; v.neg = ng;
    v.pf = f_p; v.nf = f_n; v.any = |{p, ng};
    for (int r = 0; r < rep; r++) vecs.push_back(v);
  endfunction

  // Clear held high: a sticky flag then mirrors its pulse for exactly one cycle.
  function automatic void addd(input int rep, input logic rst, input logic [3:0] n,
                               input logic [3:0] cd, input logic [3:0] p,
                               input logic [3:0] ng);
    add(rep, rst, n, 4'hF, cd, p, ng, STICKY ? p : 4'h0, STICKY ? ng : 4'h0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver: apply one record, clock it, compare
  task automatic apply(input int idx, input vec_t v);
    reset = v.rst; noisy = v.n; clr = v.clr;
    @(posedge clk); #1;
    chk("conditioned", idx, {4'h0, cond}, {4'h0, v.cond});
    chk("positiveedge", idx, {4'h0, pos}, {4'h0, v.pos});
    chk("negativeedge", idx, {4'h0, neg}, {4'h0, v.neg});
    chk("anyedge", idx, {7'h0, any}, {7'h0, v.any});
    chk("posflag", idx, {4'h0, pf}, {4'h0, v.pf});
    chk("negflag", idx, {4'h0, nf}, {4'h0, v.nf});
  endtask

  task automatic wide_step(input int idx, input logic [7:0] n,
                           input logic [7:0] e_cond, input logic [7:0] e_pos);
    noisy2 = n;
    @(posedge clk); #1;
    chk("w_conditioned", idx, cond2, e_cond);
    chk("w_positiveedge", idx, pos2, e_pos);
    chk("w_negativeedge", idx, neg2, 8'h00);
    chk("w_anyedge", idx, {7'h0, any2}, {7'h0, |e_pos});
    chk("w_posflag", idx, pf2, STICKY ? e_pos : 8'h00);
    chk("w_negflag", idx, nf2, 8'h00);
  endtask

  initial begin
    // reset held with all inputs high, then release: debounce from scratch
    addd(3, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    addd(5, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    addd(1, 1'b0, 4'hF, 4'hF, 4'hF, 4'h0);
    addd(1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
    addd(5, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    // clean step on ch0, up then down
    addd(5, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h1, 4'h1, 4'h1, 4'h0);
    addd(1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
    addd(5, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 bounces of 1, 2, 3 cycles are rejected, then a long hold is accepted
    for (int h = 1; h <= 3; h++) begin
      addd(h, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0);
      addd(4, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    addd(5, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h2, 4'h2, 4'h2, 4'h0);
    addd(4, 1'b0, 4'h2, 4'h2, 4'h0, 4'h0);
    addd(5, 1'b0, 4'h0, 4'h2, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h2);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 reset with counter at 2, then full restart after release
    addd(4, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    addd(2, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0);
    addd(5, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h4, 4'h4, 4'h4, 4'h0);
    addd(1, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0);
    addd(5, 1'b0, 4'h0, 4'h4, 4'h0, 4'h0);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h4);
    addd(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef INCOND_STICKY_EN
    // ch3 sticky flags: hold, set-beats-clear, later clear
    add(5,  1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1,  1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h8, 4'h0);
    add(20, 1'b0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
    add(5,  1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
    add(1,  1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8);
    add(1,  1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8);
    add(5,  1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8);
    add(1,  1'b0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h0);
    add(3,  1'b0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0);
    add(1,  1'b0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(2,  1'b0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
`endif

    foreach (vecs[i]) apply(i, vecs[i]);

    // wide instance: reset, then a 7-cycle burst reaches the counter peak without an update
    repeat (2) @(posedge clk);
    #1 reset2 = 1'b0;
    for (int j = 0; j < 18; j++) wide_step(j, (j < 7) ? 8'hFF : 8'h00, 8'h00, 8'h00);
    // simultaneous step on all 8 channels: 10-cycle latency, 8 pulses together
    for (int j = 0; j < 10; j++) wide_step(100 + j, 8'hFF, 8'h00, 8'h00);
    wide_step(110, 8'hFF, 8'hFF, 8'hFF);
    wide_step(111, 8'hFF, 8'hFF, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
